// File: rtl/mac_column_seq.sv
// Sequencer for one column of chained error-compensation MAC PEs: weight load,
// activation streaming with one-cycle compensation slots on PE error, drain, done.
module mac_column_seq #(
   parameter int N_PE  = 4,
   parameter int CNT_W = 8,
   localparam int IDX_W = (N_PE > 1) ? $clog2(N_PE) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] k_len,
   output logic             w_load_en,
   output logic [IDX_W-1:0] w_load_idx,
   input  logic             act_valid,
   input  logic [7:0]       act_data,
   output logic             act_ready,
   output logic [7:0]       mac_act,
   output logic             mac_en,
   output logic             comp_en,
   input  logic             err_in,
   output logic             out_valid,
   output logic [CNT_W-1:0] err_cnt,
   output logic             busy,
   output logic             done
);
   localparam int PH_W = $clog2(N_PE + 1) + 1;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOAD_W = 3'd1;
   localparam logic [2:0] S_STREAM = 3'd2;
   localparam logic [2:0] S_DRAIN  = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;

   logic [2:0]       state_q, state_d;
   logic [PH_W-1:0]  ph_q, ph_d;
   logic [CNT_W-1:0] klen_q, klen_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic [7:0]       mac_act_q, mac_act_d;
   logic             mac_en_q, mac_en_d;
   logic             comp_en_q, comp_en_d;
   logic [N_PE-1:0]  dly_q, dly_d;
   logic             accept;
   logic             raise_comp;

   assign act_ready  = (state_q == S_STREAM) && (cnt_q < klen_q) && !comp_en_q;
   assign accept     = act_valid && act_ready;
   // A compensation slot is never followed directly by another one.
   assign raise_comp = (state_q == S_STREAM) && err_in && !comp_en_q;

   always_comb begin
      state_d   = state_q;
      ph_d      = ph_q;
      klen_d    = klen_q;
      cnt_d     = cnt_q;
      err_cnt_d = err_cnt_q;
      mac_act_d = mac_act_q;
      mac_en_d  = 1'b0;
      comp_en_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               klen_d    = k_len;
               cnt_d     = '0;
               err_cnt_d = '0;
               ph_d      = '0;
               state_d   = S_LOAD_W;
            end
         end
         S_LOAD_W: begin
            if (ph_q == PH_W'(N_PE - 1)) begin
               ph_d    = '0;
               state_d = (klen_q == '0) ? S_DRAIN : S_STREAM;
            end else begin
               ph_d = ph_q + PH_W'(1);
            end
         end
         S_STREAM: begin
            if (accept) begin
               mac_act_d = act_data;
               mac_en_d  = 1'b1;
               cnt_d     = cnt_q + CNT_W'(1);
            end
            if (raise_comp) begin
               comp_en_d = 1'b1;
               if (err_cnt_q != '1)
                  err_cnt_d = err_cnt_q + CNT_W'(1);
            end
            // Leaving is deferred past a pending compensation slot.
            if ((cnt_d == klen_q) && !raise_comp) begin
               ph_d    = '0;
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (ph_q == PH_W'(N_PE))
               state_d = S_DONE;
            else
               ph_d = ph_q + PH_W'(1);
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      dly_d    = dly_q;
      dly_d[0] = mac_en_q;
      for (int i = 1; i < N_PE; i++)
         dly_d[i] = dly_q[i-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         ph_q      <= '0;
         klen_q    <= '0;
         cnt_q     <= '0;
         err_cnt_q <= '0;
         mac_act_q <= '0;
         mac_en_q  <= 1'b0;
         comp_en_q <= 1'b0;
         dly_q     <= '0;
      end else begin
         state_q   <= state_d;
         ph_q      <= ph_d;
         klen_q    <= klen_d;
         cnt_q     <= cnt_d;
         err_cnt_q <= err_cnt_d;
         mac_act_q <= mac_act_d;
         mac_en_q  <= mac_en_d;
         comp_en_q <= comp_en_d;
         dly_q     <= dly_d;
      end
   end

   assign w_load_en  = (state_q == S_LOAD_W);
   assign w_load_idx = w_load_en ? ph_q[IDX_W-1:0] : '0;
   assign mac_act    = mac_act_q;
   assign mac_en     = mac_en_q;
   assign comp_en    = comp_en_q;
   assign out_valid  = dly_q[N_PE-1];
   assign err_cnt    = err_cnt_q;
   assign busy       = (state_q != S_IDLE);
   assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_mac_column_seq.sv
// Directed bench for mac_column_seq: per-cycle masks from a vector table plus
// hand sequences for reset mid-job and err_cnt saturation.
module tb_mac_column_seq;
   localparam int N_PE  = 4;
   localparam int CNT_W = 8;
   localparam int WIN   = 24;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic [CNT_W-1:0] k_len;
   logic             w_load_en;
   logic [1:0]       w_load_idx;
   logic             act_valid;
   logic [7:0]       act_data;
   logic             act_ready;
   logic [7:0]       mac_act;
   logic             mac_en;
   logic             comp_en;
   logic             err_in;
   logic             out_valid;
   logic [CNT_W-1:0] err_cnt;
   logic             busy;
   logic             done;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mac_column_seq #(.N_PE(N_PE), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len),
      .w_load_en(w_load_en), .w_load_idx(w_load_idx),
      .act_valid(act_valid), .act_data(act_data), .act_ready(act_ready),
      .mac_act(mac_act), .mac_en(mac_en), .comp_en(comp_en), .err_in(err_in),
      .out_valid(out_valid), .err_cnt(err_cnt), .busy(busy), .done(done)
   );

   typedef struct {
      logic [7:0]  k;
      logic [31:0] st, err, vlow;
      logic [31:0] acc, mac, comp, ov;
      int          done_c;
      logic [7:0]  ec;
   } vec_t;

   vec_t       vt[7];
   logic [7:0] dv[8];

   function automatic logic [31:0] bm(input int b0 = -1, input int b1 = -1,
                                      input int b2 = -1, input int b3 = -1);
      logic [31:0] r = '0;
      if (b0 >= 0) r[b0] = 1'b1;
      if (b1 >= 0) r[b1] = 1'b1;
      if (b2 >= 0) r[b2] = 1'b1;
      if (b3 >= 0) r[b3] = 1'b1;
      return r;
   endfunction

   function automatic logic [31:0] rng(input int lo, input int hi);
      logic [31:0] r = '0;
      for (int i = lo; i <= hi; i++) r[i] = 1'b1;
      return r;
   endfunction

   task automatic chk(input string name, input int v, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s vec %0d: got %h expected %h", name, v, got, exp);
      end
   endtask

   task automatic run_vec(input int v);
      logic [31:0] gacc, gmac, gcomp, gov, gwl, gdone, gbusy;
      int accn, macn;
      gacc = '0; gmac = '0; gcomp = '0; gov = '0; gwl = '0; gdone = '0; gbusy = '0;
      accn = 0; macn = 0;
      for (int c = 0; c < WIN; c++) begin
         @(posedge clk); #1;
         start     = vt[v].st[c];
         err_in    = vt[v].err[c];
         act_valid = !vt[v].vlow[c];
         act_data  = dv[accn % 8];
         k_len     = (c == 0) ? vt[v].k : 8'hAA;
         @(negedge clk);
         gacc[c]  = act_valid && act_ready;
         gmac[c]  = mac_en;
         gcomp[c] = comp_en;
         gov[c]   = out_valid;
         gwl[c]   = w_load_en;
         gdone[c] = done;
         gbusy[c] = busy;
         if (mac_en) begin
            chk("mac_act", v, 32'(mac_act), 32'(dv[macn % 8]));
            macn++;
         end
         if (w_load_en) chk("w_load_idx", v, 32'(w_load_idx), 32'(c - 1));
         if (gacc[c]) accn++;
      end
      start = 1'b0; err_in = 1'b0; act_valid = 1'b0;
      chk("accept", v, gacc, vt[v].acc);
      chk("mac_en", v, gmac, vt[v].mac);
      chk("comp_en", v, gcomp, vt[v].comp);
      chk("out_valid", v, gov, vt[v].ov);
      chk("w_load_en", v, gwl, rng(1, 4));
      chk("done", v, gdone, bm(vt[v].done_c));
      chk("busy", v, gbusy, rng(1, vt[v].done_c));
      chk("err_cnt", v, 32'(err_cnt), 32'(vt[v].ec));
      $display("vec %0d k_len=%0d done@%0d err_cnt=%0d", v, vt[v].k, vt[v].done_c, err_cnt);
   endtask

   logic [31:0] zero_bus;
   int seen_done;

   initial begin
      dv = '{8'h02, 8'h03, 8'h05, 8'h07, 8'h0B, 8'h0D, 8'h11, 8'h13};
      //           k     start          err             vlow          accepts        mac_en          comp        out_valid        done ec
      vt[0] = '{8'd3, bm(0), 0, 0, bm(5,6,7),  bm(6,7,8),   0,         bm(10,11,12),   13, 8'd0};
      vt[1] = '{8'd3, bm(0), bm(6), 0, bm(5,6,8), bm(6,7,9), bm(7),   bm(10,11,13),   14, 8'd1};
      vt[2] = '{8'd2, bm(0), bm(6), 0, bm(5,6),  bm(6,7),    bm(7),     bm(10,11),      13, 8'd1};
      vt[3] = '{8'd4, bm(0), rng(5,8), 0, bm(5,7,9,10), bm(6,8,10,11), bm(6,8), bm(10,12,14,15), 16, 8'd2};
      vt[4] = '{8'd0, bm(0), bm(2,7), 0, 0,      0,          0,         0,              10, 8'd0};
      vt[5] = '{8'd3, bm(0), 0, rng(6,9), bm(5,10,11), bm(6,11,12), 0,   bm(10,15,16),   17, 8'd0};
      vt[6] = '{8'd3, bm(0,3,8,13), 0, 0, bm(5,6,7), bm(6,7,8), 0,       bm(10,11,12),   13, 8'd0};

      start = 1'b0; k_len = '0; act_valid = 1'b0; act_data = '0; err_in = 1'b0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      zero_bus = {busy, done, w_load_en, 2'(w_load_idx), act_ready, mac_en, comp_en,
                  out_valid, mac_act, err_cnt};
      chk("reset_outputs", -1, zero_bus, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int v = 0; v < 7; v++) run_vec(v);

      // Reset in cycle 6 of a job that has a compensation slot in flight.
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         start = (c == 0); k_len = 8'd3; act_valid = 1'b1;
         act_data = 8'h5A; err_in = (c == 5);
      end
      @(posedge clk); #1;
      start = 1'b0; err_in = 1'b0;
      chk("pre_reset_busy", -2, {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      zero_bus = {busy, done, w_load_en, 2'(w_load_idx), act_ready, mac_en, comp_en,
                  out_valid, mac_act, err_cnt};
      chk("async_reset", -2, zero_bus, 32'd0);
      seen_done = 0;
      repeat (3) begin
         @(negedge clk);
         if (done || busy) seen_done++;
      end
      chk("reset_idle", -2, 32'(seen_done), 32'd0);
      rst_n = 1'b1;
      act_valid = 1'b0;
      run_vec(0);

      // err_cnt saturation: errors while the source is idle keep raising slots.
      @(posedge clk); #1;
      start = 1'b1; k_len = 8'd1; act_valid = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1 err_in = 1'b1;
      repeat (600) @(posedge clk);
      #1;
      chk("err_cnt_sat", -3, 32'(err_cnt), 32'd255);
      err_in = 1'b0; act_valid = 1'b1; act_data = 8'h42;
      seen_done = 0;
      for (int c = 0; c < 30 && seen_done == 0; c++) begin
         @(negedge clk);
         if (done) seen_done = 1;
      end
      act_valid = 1'b0;
      chk("sat_job_done", -3, 32'(seen_done), 32'd1);
      chk("err_cnt_hold", -3, 32'(err_cnt), 32'd255);
      $display("saturation job err_cnt=%0d", err_cnt);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
